// File: rtl/vibrate_alarm.sv
// Four-channel vibration alarm: baseline capture, hysteretic alarm, stats.
// Optional macro VIBRATE_BASELINE_TRACK_EN: in-range samples pull baseline.
module vibrate_alarm #(
  parameter logic [15:0] THRESH    = 16'd100,
  parameter logic [7:0]  HOLD_CNT  = 8'd3,
  parameter logic [7:0]  CLEAR_CNT = 8'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] AData0,
  input  logic [15:0] AData1,
  input  logic [15:0] AData2,
  input  logic [15:0] AData3,
  input  logic        AData0_en,
  input  logic        AData1_en,
  input  logic        AData2_en,
  input  logic        AData3_en,
  output logic [3:0]  alarm,
  output logic        alarm_any,
  output logic [15:0] max_dev,
  output logic [7:0]  event_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } state_t;

  logic [15:0] din [4];
  logic [3:0]  en;
  logic [3:0]  en_d;
  logic [3:0]  ev;
  logic [3:0]  pend;

  logic [15:0] sample_q [4];
  logic [15:0] base_q   [4];
  logic [15:0] base_n   [4];
  logic [7:0]  over_q   [4];
  logic [7:0]  over_n   [4];
  logic [7:0]  in_q     [4];
  logic [7:0]  in_n     [4];
  state_t      state_q  [4];
  state_t      state_n  [4];

  logic [15:0] dev      [4];
  logic [7:0]  over_inc [4];
  logic [7:0]  in_inc   [4];
  logic [16:0] avg_sum  [4];
  logic [3:0]  exceed;
  logic [3:0]  enter;
  logic [15:0] max_n;
  logic [8:0]  ev_sum;
  logic [7:0]  event_n;

  assign din[0] = AData0;
  assign din[1] = AData1;
  assign din[2] = AData2;
  assign din[3] = AData3;
  assign en     = {AData3_en, AData2_en, AData1_en, AData0_en};
  assign ev     = en_d & ~en;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    assign dev[g] = (sample_q[g] >= base_q[g]) ?
                    sample_q[g] - base_q[g] :
                    base_q[g] - sample_q[g];
    assign exceed[g]   = dev[g] > THRESH;
    assign over_inc[g] = (over_q[g] == 8'hFF) ? 8'hFF : over_q[g] + 8'd1;
    assign in_inc[g]   = (in_q[g] == 8'hFF) ? 8'hFF : in_q[g] + 8'd1;
    assign avg_sum[g]  = {1'b0, base_q[g]} + {1'b0, sample_q[g]};
    assign alarm[g]    = (state_q[g] == ALARM);
  end

  always_comb begin
    enter  = '0;
    max_n  = max_dev;
    for (int i = 0; i < 4; i++) begin
      state_n[i] = state_q[i];
      base_n[i]  = base_q[i];
      over_n[i]  = over_q[i];
      in_n[i]    = in_q[i];
      if (pend[i]) begin
        unique case (state_q[i])
          IDLE: begin
            base_n[i]  = sample_q[i];
            state_n[i] = ARMED;
          end
          ARMED: begin
            if (dev[i] > max_n) max_n = dev[i];
            if (exceed[i]) begin
              if (over_inc[i] >= HOLD_CNT) begin
                state_n[i] = ALARM;
                over_n[i]  = '0;
                enter[i]   = 1'b1;
              end else begin
                over_n[i] = over_inc[i];
              end
            end else begin
              over_n[i] = '0;
`ifdef VIBRATE_BASELINE_TRACK_EN
              base_n[i] = avg_sum[i][16:1];
`endif
            end
          end
          ALARM: begin
            if (dev[i] > max_n) max_n = dev[i];
            if (!exceed[i]) begin
              if (in_inc[i] >= CLEAR_CNT) begin
                state_n[i] = ARMED;
                in_n[i]    = '0;
              end else begin
                in_n[i] = in_inc[i];
              end
            end else begin
              in_n[i] = '0;
            end
          end
          default: state_n[i] = IDLE;
        endcase
      end
    end
    ev_sum = {1'b0, event_cnt};
    for (int i = 0; i < 4; i++) begin
      ev_sum = ev_sum + {8'd0, enter[i]};
    end
    event_n = ev_sum[8] ? 8'hFF : ev_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d      <= '0;
      pend      <= '0;
      alarm_any <= 1'b0;
      max_dev   <= '0;
      event_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= IDLE;
        sample_q[i] <= '0;
        base_q[i]   <= '0;
        over_q[i]   <= '0;
        in_q[i]     <= '0;
      end
    end else begin
      en_d <= en;
      if (clr) begin
        pend      <= '0;
        alarm_any <= 1'b0;
        max_dev   <= '0;
        event_cnt <= '0;
        for (int i = 0; i < 4; i++) begin
          state_q[i]  <= IDLE;
          sample_q[i] <= '0;
          base_q[i]   <= '0;
          over_q[i]   <= '0;
          in_q[i]     <= '0;
        end
      end else begin
        pend      <= ev;
        alarm_any <= |alarm;
        max_dev   <= max_n;
        event_cnt <= event_n;
        for (int i = 0; i < 4; i++) begin
          if (ev[i]) sample_q[i] <= din[i];
          state_q[i] <= state_n[i];
          base_q[i]  <= base_n[i];
          over_q[i]  <= over_n[i];
          in_q[i]    <= in_n[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vibrate_alarm.sv
// Directed bench for vibrate_alarm with hand-computed expectations.
// Honors VIBRATE_BASELINE_TRACK_EN where expected values differ.
module tb_vibrate_alarm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] AData0 = '0;
  logic [15:0] AData1 = '0;
  logic [15:0] AData2 = '0;
  logic [15:0] AData3 = '0;
  logic        AData0_en = 1'b0;
  logic        AData1_en = 1'b0;
  logic        AData2_en = 1'b0;
  logic        AData3_en = 1'b0;
  logic [3:0]  alarm;
  logic        alarm_any;
  logic [15:0] max_dev;
  logic [7:0]  event_cnt;

  int vecs = 0;
  int errs = 0;

  vibrate_alarm dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .AData0    (AData0),
    .AData1    (AData1),
    .AData2    (AData2),
    .AData3    (AData3),
    .AData0_en (AData0_en),
    .AData1_en (AData1_en),
    .AData2_en (AData2_en),
    .AData3_en (AData3_en),
    .alarm     (alarm),
    .alarm_any (alarm_any),
    .max_dev   (max_dev),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [3:0] m);
    AData0_en = m[0];
    AData1_en = m[1];
    AData2_en = m[2];
    AData3_en = m[3];
  endtask

  // Enable high one cycle, then fall; returns just after the eval edge.
  task automatic pulse(input logic [3:0] m, input logic [15:0] d);
    if (m[0]) AData0 = d;
    if (m[1]) AData1 = d;
    if (m[2]) AData2 = d;
    if (m[3]) AData3 = d;
    set_en(m);
    tick();
    set_en(4'h0);
    tick();
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_any", 32'(alarm_any), 32'd0);
    chk("rst_max", 32'(max_dev), 32'd0);
    chk("rst_evt", 32'(event_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // ch0 rises to alarm
    pulse(4'h1, 16'd1000);
    pulse(4'h1, 16'd1050);
    pulse(4'h1, 16'd1200);
    pulse(4'h1, 16'd1200);
    chk("pre_alarm", 32'(alarm), 32'd0);
    pulse(4'h1, 16'd1200);
    chk("a0_rise", 32'(alarm), 32'd1);
    chk("a0_evt", 32'(event_cnt), 32'd1);
`ifdef VIBRATE_BASELINE_TRACK_EN
    chk("a0_max", 32'(max_dev), 32'd175);
`else
    chk("a0_max", 32'(max_dev), 32'd200);
`endif
    chk("any_lag", 32'(alarm_any), 32'd0);
    tick();
    chk("any_set", 32'(alarm_any), 32'd1);

    // ch0 clears after two in-range samples
    pulse(4'h1, 16'd1000);
    chk("a0_hold", 32'(alarm), 32'd1);
    pulse(4'h1, 16'd1000);
    chk("a0_clear", 32'(alarm), 32'd0);
    chk("a0_evt2", 32'(event_cnt), 32'd1);

    do_clr();
    chk("clr_max", 32'(max_dev), 32'd0);
    chk("clr_evt", 32'(event_cnt), 32'd0);

    // ch1 deviation exactly at threshold never alarms
    pulse(4'h2, 16'd500);
    for (int i = 0; i < 5; i++) pulse(4'h2, 16'd600);
    chk("th_alarm", 32'(alarm), 32'd0);
    chk("th_max", 32'(max_dev), 32'd100);

    // ch2 and ch3 alarm together
    pulse(4'hC, 16'd100);
    pulse(4'hC, 16'd300);
    pulse(4'hC, 16'd300);
    chk("c23_pre", 32'(alarm), 32'd0);
    pulse(4'hC, 16'd300);
    chk("c23_alarm", 32'(alarm), 32'd12);
    chk("c23_evt", 32'(event_cnt), 32'd2);
    chk("c23_max", 32'(max_dev), 32'd200);

    // clr coincident with a ch0 falling edge drops that sample
    AData0 = 16'd9000;
    set_en(4'h1);
    tick();
    set_en(4'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("cc_alarm", 32'(alarm), 32'd0);
    chk("cc_any", 32'(alarm_any), 32'd0);
    chk("cc_max", 32'(max_dev), 32'd0);
    chk("cc_evt", 32'(event_cnt), 32'd0);
    pulse(4'h1, 16'd5000);
    chk("cc_base", 32'(max_dev), 32'd0);
    pulse(4'h1, 16'd5050);
    chk("cc_dev", 32'(max_dev), 32'd50);

    // absolute difference does not wrap
    do_clr();
    pulse(4'h4, 16'hFFFF);
    pulse(4'h4, 16'd0);
    chk("nowrap", 32'(max_dev), 32'd65535);

    // event counter saturates
    do_clr();
    pulse(4'hF, 16'd0);
    for (int r = 0; r < 64; r++) begin
      for (int k = 0; k < 3; k++) pulse(4'hF, 16'd1000);
      for (int k = 0; k < 2; k++) pulse(4'hF, 16'd0);
    end
    chk("sat_evt", 32'(event_cnt), 32'd255);
    chk("sat_alarm", 32'(alarm), 32'd0);

    // reset mid-alarm drops everything without a clock edge
    do_clr();
    pulse(4'h1, 16'd1000);
    for (int k = 0; k < 3; k++) pulse(4'h1, 16'd1200);
    chk("pre_rst", 32'(alarm), 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_alarm", 32'(alarm), 32'd0);
    chk("arst_any", 32'(alarm_any), 32'd0);
    chk("arst_max", 32'(max_dev), 32'd0);
    chk("arst_evt", 32'(event_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // first post-reset sample is baseline; tracking shifts later dev
    pulse(4'h1, 16'd1000);
    chk("pr_base", 32'(max_dev), 32'd0);
    pulse(4'h1, 16'd1060);
    chk("pr_dev", 32'(max_dev), 32'd60);
    pulse(4'h1, 16'd1131);
`ifdef VIBRATE_BASELINE_TRACK_EN
    chk("track", 32'(max_dev), 32'd101);
`else
    chk("track", 32'(max_dev), 32'd131);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vibrate_alarm.md
VIBRATE_ALARM -- requirements
Module: vibrate_alarm

Interface
REQ-001 SHALL have parameter THRESH, default 16'd100: deviation limit; exceed when dev > THRESH.
REQ-002 SHALL have parameter HOLD_CNT, default 8'd3: consecutive exceeding samples needed to raise an alarm, range 1..255.
REQ-003 SHALL have parameter CLEAR_CNT, default 8'd2: consecutive in-range samples needed to drop an alarm, range 1..255.
REQ-004 SHALL have port clk  in  1: sole clock, rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port clr  in  1: synchronous clear pulse; clears alarms and counters and re-arms baseline capture.
REQ-007 SHALL have ports AData0..AData3  in  16 each: averaged unsigned samples from the averaging stage.
REQ-008 SHALL have ports AData0_en..AData3_en  in  1 each: level enables from the averaging stage.
REQ-009 SHALL have port alarm  out  4: per-channel alarm flags, bit n = channel n.
REQ-010 SHALL have port alarm_any  out  1: registered OR of alarm.
REQ-011 SHALL have port max_dev  out  16: peak deviation seen on any channel since reset or clr.
REQ-012 SHALL have port event_cnt  out  8: count of alarm rising edges across all channels, saturating at 255.

Function
REQ-013 SHALL register each ADataN_en once, giving en_d; a sample event occurs at the edge where en_d=1 and ADataN_en=0 (falling edge), because upstream data settles after the enable rises.
REQ-014 SHALL capture ADataN into a per-channel sample register at the event edge k, and evaluate it at edge k+1; alarm/max_dev/event_cnt update at edge k+1, alarm_any at edge k+2.
REQ-015 SHALL run one 2-bit FSM per channel, with states IDLE, ARMED and ALARM.
REQ-016 IDLE: the first evaluated sample SHALL load the baseline and move to ARMED; it never counts as an exceedance.
REQ-017 SHALL compute dev = |sample - baseline| as a 16-bit unsigned absolute difference with no wrap (sample 0, baseline 65535 -> dev 65535).
REQ-018 ARMED: dev > THRESH SHALL increment over_cnt (8-bit, saturating); dev <= THRESH SHALL zero it; when over_cnt would reach HOLD_CNT, the FSM SHALL enter ALARM, set alarm[n], and zero over_cnt.
REQ-019 ALARM: dev <= THRESH SHALL increment in_cnt (8-bit, saturating); dev > THRESH SHALL zero it; when in_cnt would reach CLEAR_CNT, the FSM SHALL return to ARMED, clear alarm[n], and zero in_cnt.
REQ-020 SHALL, at every evaluation, update max_dev <= dev if dev > max_dev; the IDLE baseline-load evaluation is excluded.
REQ-021 SHALL increment event_cnt once per channel entering ALARM; simultaneous entries on k channels in one cycle SHALL add k, saturating at 255.
REQ-022 SHALL process the four channels independently; simultaneous events on several channels SHALL all be processed in the same cycle.
REQ-023 SHALL let clr take precedence: in the clr cycle, pending and arriving samples are discarded, all FSMs go to IDLE, and alarm, max_dev, event_cnt, counters and baselines are zeroed.
REQ-024 A held-high or held-low enable SHALL generate no events.

Reset
REQ-025 rst low SHALL asynchronously force all FSMs to IDLE and alarm=0, alarm_any=0, max_dev=0, event_cnt=0, with en_d, sample, baseline and counter registers zeroed.
REQ-026 Reset asserted mid-alarm SHALL drop alarm immediately; after release, the first falling enable edge SHALL be treated as a baseline sample.

Configuration
REQ-027 With macro VIBRATE_BASELINE_TRACK_EN defined, each in-range (dev <= THRESH) evaluation in ARMED SHALL set baseline <= (baseline + sample) >> 1 using a 17-bit sum.
REQ-028 Without VIBRATE_BASELINE_TRACK_EN, the baseline SHALL stay fixed from the IDLE capture until clr or reset.

Verification
REQ-029 Ch0 samples 1000, 1050, 1200, 1200, 1200 -> alarm[0] rises 1 cycle after the 5th falling edge; event_cnt=1; max_dev=200; alarm_any follows one cycle later.
REQ-030 Continue ch0 with 1000, 1000 -> alarm[0] stays high after the first and clears after the second; event_cnt stays 1.
REQ-031 Ch1 baseline 500, then samples 600 x5 (dev exactly 100) -> alarm[1] stays 0; max_dev=100.
REQ-032 Ch2 and ch3 reach HOLD_CNT in the same cycle -> alarm=4'b1100, event_cnt increments by 2.
REQ-033 clr asserted on the same edge as a ch0 falling enable edge -> sample dropped, all outputs 0; the next ch0 sample becomes the baseline.
REQ-034 rst pulled low while alarm[0]=1 -> alarm=0 without a clock edge; with VIBRATE_BASELINE_TRACK_EN, baseline 1000 then sample 1060 -> baseline reads 1030.
